jpc_ifetch: RTL and testbench

Instruction-fetch initiator for the JPC core's single-port instruction BRAM. Drives the BRAM address/write port, absorbs its one-cycle registered read latency, and presents a stream of (pc, instruction) pairs to the decoder over a valid/ready handshake through a 2-entry buffer. Also accepts program-load writes that share the BRAM port and take priority over fetch. Sits between the instruction BRAM and the decode stage.

---
 rtl/jpc_ifetch_if.sv | 33 +++
 rtl/jpc_ifetch.sv | 117 +++++++++++
 tb/tb_jpc_ifetch.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/jpc_ifetch_if.sv
// Bundle of the fetch unit's control, program-load, BRAM and decoder-side signals.
// master = fetch unit, slave = its environment (BRAM, loader, decoder).
`ifndef JPC_ADDRESS_WIDTH
`define JPC_ADDRESS_WIDTH 16
`endif

interface jpc_ifetch_if;
  logic                          en;
  logic                          pc_load;
  logic [`JPC_ADDRESS_WIDTH-1:0] pc_target;
  logic                          ld_valid;
  logic [`JPC_ADDRESS_WIDTH-1:0] ld_addr;
  logic [`JPC_ADDRESS_WIDTH-1:0] ld_data;
  logic                          ld_ready;
  logic [`JPC_ADDRESS_WIDTH-1:0] mem_addr;
  logic [`JPC_ADDRESS_WIDTH-1:0] mem_din;
  logic                          mem_we;
  logic [`JPC_ADDRESS_WIDTH-1:0] mem_dout;
  logic                          instr_valid;
  logic                          instr_ready;
  logic [`JPC_ADDRESS_WIDTH-1:0] instr_data;
  logic [`JPC_ADDRESS_WIDTH-1:0] instr_pc;

  modport master (
    input  en, pc_load, pc_target, ld_valid, ld_addr, ld_data, mem_dout, instr_ready,
    output ld_ready, mem_addr, mem_din, mem_we, instr_valid, instr_data, instr_pc
  );

  modport slave (
    output en, pc_load, pc_target, ld_valid, ld_addr, ld_data, mem_dout, instr_ready,
    input  ld_ready, mem_addr, mem_din, mem_we, instr_valid, instr_data, instr_pc
  );
endinterface

// File: rtl/jpc_ifetch.sv
// Instruction-fetch initiator: drives the single-port instruction BRAM, hides its
// one-cycle read latency and streams (pc, instruction) pairs through a 2-entry buffer.
`ifndef JPC_ADDRESS_WIDTH
`define JPC_ADDRESS_WIDTH 16
`endif

module jpc_ifetch #(
  parameter int DEPTH    = 256,
  parameter int RESET_PC = 0
) (
  input  logic         clk,
  input  logic         rst,
  jpc_ifetch_if.master bus
);
  localparam int            AW       = `JPC_ADDRESS_WIDTH;
  localparam logic [AW-1:0] LAST_PC  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] START_PC = AW'(RESET_PC);
  localparam logic [AW-1:0] ZERO_W   = {AW{1'b0}};
  localparam logic [AW-1:0] ONE_W    = {{(AW-1){1'b0}}, 1'b1};

  logic [AW-1:0] r_pc;
  logic          r_inflight;
  logic [AW-1:0] r_inflight_pc;
  logic [AW-1:0] r_fifo_pc   [2];
  logic [AW-1:0] r_fifo_data [2];
  logic          r_rd_ptr;
  logic          r_wr_ptr;
  logic [1:0]    r_count;

  logic          w_valid;
  logic          w_pop;
  logic          w_push;
  logic          w_issue;
  logic [2:0]    w_occupancy;
  logic [AW-1:0] w_pc_next;
  logic          w_mem_we;
  logic [AW-1:0] w_mem_addr;
  logic [AW-1:0] w_mem_din;

  // Handshake, issue decision and BRAM port arbitration (load write beats fetch).
  always_comb begin
    w_valid     = 1'b0;
    w_pop       = 1'b0;
    w_push      = 1'b0;
    w_issue     = 1'b0;
    w_occupancy = 3'd0;
    w_pc_next   = ZERO_W;
    w_mem_we    = 1'b0;
    w_mem_addr  = r_pc;
    w_mem_din   = ZERO_W;

    w_valid     = (r_count != 2'd0) && !bus.pc_load;
    w_pop       = w_valid && bus.instr_ready;
    w_push      = r_inflight && !bus.pc_load;
    // Slots already promised: buffered + the read returning next cycle, minus what leaves now.
    w_occupancy = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    w_issue     = bus.en && !bus.ld_valid && !bus.pc_load && (w_occupancy < 3'd2);
    w_pc_next   = (r_pc == LAST_PC) ? ZERO_W : (r_pc + ONE_W);

    if (bus.ld_valid && !rst) begin
      w_mem_we   = 1'b1;
      w_mem_addr = bus.ld_addr;
      w_mem_din  = bus.ld_data;
    end else begin
      w_mem_we   = 1'b0;
      w_mem_addr = r_pc;
      w_mem_din  = ZERO_W;
    end
  end

  assign bus.mem_we      = w_mem_we;
  assign bus.mem_addr    = w_mem_addr;
  assign bus.mem_din     = w_mem_din;
  assign bus.ld_ready    = !rst;
  assign bus.instr_valid = w_valid;
  assign bus.instr_pc    = r_fifo_pc[r_rd_ptr];
  assign bus.instr_data  = r_fifo_data[r_rd_ptr];

  // Fetch pointer, in-flight tracking and response buffer; a redirect flushes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc           <= START_PC;
      r_inflight     <= 1'b0;
      r_inflight_pc  <= ZERO_W;
      r_fifo_pc[0]   <= ZERO_W;
      r_fifo_pc[1]   <= ZERO_W;
      r_fifo_data[0] <= ZERO_W;
      r_fifo_data[1] <= ZERO_W;
      r_rd_ptr       <= 1'b0;
      r_wr_ptr       <= 1'b0;
      r_count        <= 2'd0;
    end else if (bus.pc_load) begin
      r_pc       <= bus.pc_target;
      r_inflight <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_count    <= 2'd0;
    end else begin
      if (w_issue) begin
        r_inflight    <= 1'b1;
        r_inflight_pc <= r_pc;
        r_pc          <= w_pc_next;
      end else begin
        r_inflight    <= 1'b0;
      end
      if (w_push) begin
        r_fifo_pc[r_wr_ptr]   <= r_inflight_pc;
        r_fifo_data[r_wr_ptr] <= bus.mem_dout;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end
endmodule

// File: tb/tb_jpc_ifetch.sv
// Randomized bench for jpc_ifetch against a queue-based transaction model,
// plus a DEPTH=8 instance streaming from pc 6 to exercise the wrap.
`ifndef JPC_ADDRESS_WIDTH
`define JPC_ADDRESS_WIDTH 16
`endif

module tb_jpc_ifetch;
  localparam int AW    = `JPC_ADDRESS_WIDTH;
  localparam int DEPTH = 256;

  typedef struct {
    logic [AW-1:0] pc;
    logic [AW-1:0] data;
  } entry_t;

  logic clk;
  logic rst;
  logic preload;

  jpc_ifetch_if bus ();
  jpc_ifetch_if bus8 ();

  jpc_ifetch #(.DEPTH(DEPTH), .RESET_PC(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  jpc_ifetch #(.DEPTH(8), .RESET_PC(6)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  logic [AW-1:0] bram  [256];
  logic [AW-1:0] bram8 [8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first single-port BRAMs with registered output.
  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < 256; k++) bram[k] <= AW'(32'h1000 + k);
      for (int k = 0; k < 8; k++) bram8[k] <= AW'(32'h0800 + k);
    end else begin
      if (bus.mem_we) bram[bus.mem_addr[7:0]] <= bus.mem_din;
      if (bus8.mem_we) bram8[bus8.mem_addr[2:0]] <= bus8.mem_din;
    end
    bus.mem_dout  <= bram[bus.mem_addr[7:0]];
    bus8.mem_dout <= bram8[bus8.mem_addr[2:0]];
  end

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [AW-1:0] m_mem [256];
  entry_t        m_q [$];
  int            m_pc;
  bit            m_inf;
  logic [AW-1:0] m_inf_pc;
  logic [AW-1:0] m_inf_data;
  int            s8_cyc;
  int            e8;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc   = 0;
    m_inf  = 1'b0;
    s8_cyc = 0;
    e8     = 6;
  endtask

  // Entered just after a falling edge; drives one cycle, checks, advances the model.
  task automatic step(input logic en, input logic pcl, input logic [AW-1:0] tgt,
                      input logic ldv, input logic [AW-1:0] lda, input logic [AW-1:0] ldd,
                      input logic rdy);
    logic exp_valid;
    logic pop;
    logic issue;
    int   occ;
    bus.en          = en;
    bus.pc_load     = pcl;
    bus.pc_target   = tgt;
    bus.ld_valid    = ldv;
    bus.ld_addr     = lda;
    bus.ld_data     = ldd;
    bus.instr_ready = rdy;
    #1;
    exp_valid = (m_q.size() != 0) && !pcl;
    pop       = exp_valid && rdy;
    check_eq("instr_valid", bus.instr_valid, exp_valid);
    if (exp_valid) begin
      check_eq("instr_pc", bus.instr_pc, m_q[0].pc);
      check_eq("instr_data", bus.instr_data, m_q[0].data);
    end
    check_eq("ld_ready", bus.ld_ready, 1);
    check_eq("mem_we", bus.mem_we, ldv);
    check_eq("mem_addr", bus.mem_addr, ldv ? lda : AW'(m_pc));
    check_eq("mem_din", bus.mem_din, ldv ? ldd : 0);

    check_eq("d8_valid", bus8.instr_valid, s8_cyc >= 2);
    if (s8_cyc >= 2) begin
      check_eq("d8_pc", bus8.instr_pc, e8);
      check_eq("d8_data", bus8.instr_data, 32'h0800 + e8);
      e8 = (e8 + 1) % 8;
    end
    s8_cyc++;

    occ   = m_q.size() + int'(m_inf) - int'(pop);
    issue = en && !ldv && !pcl && (occ < 2);
    if (pcl) begin
      m_q.delete();
      m_inf = 1'b0;
      m_pc  = int'(tgt);
    end else begin
      if (pop) void'(m_q.pop_front());
      if (m_inf) m_q.push_back('{pc: m_inf_pc, data: m_inf_data});
      if (issue) begin
        m_inf_data = m_mem[m_pc];
        m_inf_pc   = AW'(m_pc);
        m_inf      = 1'b1;
        m_pc       = (m_pc + 1) % DEPTH;
      end else begin
        m_inf = 1'b0;
      end
    end
    if (ldv) m_mem[lda[7:0]] = ldd;
    @(negedge clk);
  endtask

  task automatic run_random(input int n, input int p_en, input int p_pcl, input int p_ld,
                            input int p_rdy);
    for (int i = 0; i < n; i++) begin
      step($urandom_range(99) < p_en, $urandom_range(99) < p_pcl, AW'($urandom_range(255)),
           $urandom_range(99) < p_ld, AW'($urandom_range(255)), AW'($urandom),
           $urandom_range(99) < p_rdy);
    end
  endtask

  initial begin
    rst              = 1'b1;
    preload          = 1'b1;
    bus.en           = 1'b0;
    bus.pc_load      = 1'b0;
    bus.pc_target    = '0;
    bus.ld_valid     = 1'b0;
    bus.ld_addr      = '0;
    bus.ld_data      = '0;
    bus.instr_ready  = 1'b0;
    bus8.en          = 1'b1;
    bus8.pc_load     = 1'b0;
    bus8.pc_target   = '0;
    bus8.ld_valid    = 1'b0;
    bus8.ld_addr     = '0;
    bus8.ld_data     = '0;
    bus8.instr_ready = 1'b1;
    for (int k = 0; k < 256; k++) m_mem[k] = AW'(32'h1000 + k);
    model_reset();

    @(negedge clk);
    preload = 1'b0;
    @(negedge clk);
    #1;
    check_eq("rst_valid", bus.instr_valid, 0);
    check_eq("rst_data", bus.instr_data, 0);
    check_eq("rst_pc", bus.instr_pc, 0);
    check_eq("rst_we", bus.mem_we, 0);
    check_eq("rst_din", bus.mem_din, 0);
    check_eq("rst_ld_ready", bus.ld_ready, 0);
    check_eq("rst_d8_valid", bus8.instr_valid, 0);
    @(negedge clk);
    rst = 1'b0;

    // Streaming, backpressure, release
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 0, 1);

    // Redirect with buffer filling and a read in flight
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, AW'(16'h0020), 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 0, 1);

    // Program-load writes during fetch, then fetch the rewritten words
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1, AW'(4 + i), AW'(16'h000A + i), 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 1);
    step(1, 1, AW'(16'h0004), 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, 0, 1);

    run_random(3000, 85, 5, 10, 70);

    // Reset mid-stream with both buffer entries occupied
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_valid", bus.instr_valid, 0);
    check_eq("mid_rst_pc", bus.instr_pc, 0);
    check_eq("mid_rst_data", bus.instr_data, 0);
    check_eq("mid_rst_ld_ready", bus.ld_ready, 0);
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 0, 1);
    run_random(1000, 90, 3, 8, 80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
